// File: rtl/mem_access_unit.sv
// Data-memory access stage: one load/store at a time, byte-lane steering, load extension, ack timeout.
// Optional feature: define MISALIGN_TRAP_EN to fault misaligned halfword/word accesses instead of aligning them.
module mem_access_unit #(
    parameter int XLEN       = 32,
    parameter int DATA_WIDTH = 3,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_load,
    input  logic                  req_store,
    input  logic [XLEN-1:0]       req_addr,
    input  logic [DATA_WIDTH-1:0] req_width,
    input  logic [XLEN-1:0]       req_wdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [XLEN-1:0]       mem_addr,
    output logic [XLEN/8-1:0]     mem_be,
    output logic [XLEN-1:0]       mem_wdata,
    input  logic                  mem_ack,
    input  logic [XLEN-1:0]       mem_rdata,
    output logic                  resp_valid,
    output logic [XLEN-1:0]       resp_rdata,
    output logic                  resp_fault,
    output logic                  busy
);
    localparam int NB = XLEN / 8;
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [DATA_WIDTH-1:0] W_WORD  = DATA_WIDTH'(0);
    localparam logic [DATA_WIDTH-1:0] W_HALF  = DATA_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] W_BYTE  = DATA_WIDTH'(2);
    localparam logic [DATA_WIDTH-1:0] W_BYTEU = DATA_WIDTH'(3);
    localparam logic [DATA_WIDTH-1:0] W_HALFU = DATA_WIDTH'(4);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                state;
    logic [CW-1:0]         count;
    logic [1:0]            lane;
    logic [DATA_WIDTH-1:0] width_q;

    logic [1:0]            off;
    logic                  fault_imm;
    logic [NB-1:0]         be_next;
    logic [XLEN-1:0]       wdata_next;
`ifdef MISALIGN_TRAP_EN
    logic                  misalign;
`endif

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        off        = 2'd0;
        be_next    = '1;
        wdata_next = req_wdata;
`ifdef MISALIGN_TRAP_EN
        misalign   = 1'b0;
`endif
        case (req_width)
            W_BYTE, W_BYTEU: begin
                off        = req_addr[1:0];
                be_next    = NB'(1) << off;
                wdata_next = {NB{req_wdata[7:0]}};
            end
            W_HALF, W_HALFU: begin
                off        = {req_addr[1], 1'b0};
                be_next    = NB'(3) << off;
                wdata_next = {(NB/2){req_wdata[15:0]}};
`ifdef MISALIGN_TRAP_EN
                misalign   = req_addr[0];
`endif
            end
            default: begin
`ifdef MISALIGN_TRAP_EN
                misalign   = |req_addr[1:0];
`endif
            end
        endcase

        fault_imm = (req_load && req_store) || (req_width > W_HALFU) ||
                    (req_store && (req_width == W_BYTEU || req_width == W_HALFU));
`ifdef MISALIGN_TRAP_EN
        fault_imm = fault_imm || misalign;
`endif
    end

    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] load_data;

    always_comb begin
        shifted = mem_rdata >> {lane, 3'b000};
        case (width_q)
            W_BYTE:  load_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            W_BYTEU: load_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
            W_HALF:  load_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            W_HALFU: load_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    // NOTE: req_ready is a register so it stays low during reset and rises on the first edge after.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            lane       <= '0;
            width_q    <= '0;
            req_ready  <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
            resp_valid <= 1'b0;
            resp_fault <= 1'b0;
            resp_rdata <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready && (req_load || req_store)) begin
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        lane      <= off;
                        width_q   <= req_width;
                        if (fault_imm) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_fault <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            state     <= ACCESS;
                            count     <= '0;
                            mem_req   <= 1'b1;
                            mem_we    <= req_store;
                            mem_addr  <= {req_addr[XLEN-1:2], 2'b00};
                            mem_be    <= be_next;
                            mem_wdata <= wdata_next;
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ack) begin
                        state      <= RESP;
                        mem_req    <= 1'b0;
                        mem_we     <= 1'b0;
                        mem_be     <= '0;
                        resp_valid <= 1'b1;
                        resp_fault <= 1'b0;
                        resp_rdata <= mem_we ? '0 : load_data;
                    end else if (count == CW'(TIMEOUT - 1)) begin
                        // Last allowed request cycle passed without ack.
                        state      <= RESP;
                        mem_req    <= 1'b0;
                        mem_we     <= 1'b0;
                        mem_be     <= '0;
                        resp_valid <= 1'b1;
                        resp_fault <= 1'b1;
                        resp_rdata <= '0;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    resp_fault <= 1'b0;
                    resp_rdata <= '0;
                    busy       <= 1'b0;
                    req_ready  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized requests against an arithmetic model.
module tb_mem_access_unit;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_load, req_store;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_width;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        resp_valid, resp_fault, busy;
    logic [31:0] resp_rdata;

    int total  = 0;
    int passed = 0;

    mem_access_unit #(.XLEN(32), .DATA_WIDTH(3), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load), .req_store(req_store),
        .req_addr(req_addr), .req_width(req_width), .req_wdata(req_wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One request from presentation to the idle cycle after its response.
    task automatic do_req(input logic ld, input logic st, input logic [31:0] addr,
                          input logic [2:0] w, input logic [31:0] wd, input logic [31:0] rd,
                          input int ack_delay);
        int unsigned off, v, exp_be, exp_wd, exp_rd;
        bit illegal, got;
        int n;

        illegal = (ld && st) || (w > 4) || (st && w >= 3);
`ifdef MISALIGN_TRAP_EN
        if ((w == 1 || w == 4) && addr % 2 != 0) illegal = 1;
        if (w == 0 && addr % 4 != 0) illegal = 1;
`endif
        if (w == 2 || w == 3)      begin off = addr % 4;           exp_be = 1 << off; exp_wd = (wd % 256) * 32'h01010101; end
        else if (w == 1 || w == 4) begin off = (addr % 4) / 2 * 2; exp_be = 3 << off; exp_wd = (wd % 65536) * 32'h00010001; end
        else                       begin off = 0;                  exp_be = 15;       exp_wd = wd; end
        v = rd >> (8 * off);
        case (w)
            3'd2:    exp_rd = (v % 256 >= 128) ? (v % 256) - 256 : v % 256;
            3'd3:    exp_rd = v % 256;
            3'd1:    exp_rd = (v % 65536 >= 32768) ? (v % 65536) - 65536 : v % 65536;
            3'd4:    exp_rd = v % 65536;
            default: exp_rd = rd;
        endcase
        if (st || illegal) exp_rd = 0;

        @(negedge clk);
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        check("req_ready_idle", req_ready, 1);
        req_valid = 1; req_load = ld; req_store = st; req_addr = addr; req_width = w; req_wdata = wd;
        @(negedge clk);
        req_valid = 0; req_load = 0; req_store = 0;

        if (!ld && !st) begin
            check("noop_busy", busy, 0);
            check("noop_ready", req_ready, 1);
            check("noop_resp", resp_valid, 0);
            return;
        end

        got = 0;
        if (!illegal) begin
            for (int c = 1; c <= TO; c++) begin
                check("mem_req_hi", mem_req, 1);
                check("mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
                check("mem_be", mem_be, exp_be);
                check("mem_we", mem_we, st);
                if (st) check("mem_wdata", mem_wdata, exp_wd);
                check("resp_idle", resp_valid, 0);
                check("busy_access", busy, 1);
                if (c == ack_delay) begin mem_ack = 1; mem_rdata = rd; end
                @(negedge clk);
                mem_ack = 0; mem_rdata = $urandom;
                if (c == ack_delay) begin got = 1; break; end
            end
        end
        check("resp_valid", resp_valid, 1);
        check("resp_fault", resp_fault, illegal || !got);
        check("resp_rdata", resp_rdata, got ? exp_rd : 0);
        check("mem_req_resp", mem_req, 0);
        check("ready_resp", req_ready, 0);
        @(negedge clk);
        check("resp_pulse", resp_valid, 0);
        check("ready_back", req_ready, 1);
        check("busy_clear", busy, 0);
    endtask

    initial begin
        rst = 1; req_valid = 0; req_load = 0; req_store = 0; req_addr = 0; req_width = 0;
        req_wdata = 0; mem_ack = 0; mem_rdata = 0;
        #7;
        check("rst_ready", req_ready, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_busy", busy, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        @(negedge clk); rst = 0;

        do_req(1, 0, 32'h103, 3'd2, 0, 32'h80AABBCC, 3);
        do_req(0, 1, 32'h22, 3'd1, 32'h1234ABCD, 0, 2);
        do_req(1, 0, 32'h2, 3'd4, 0, 32'hF00D0000, 1);
        do_req(1, 0, 32'h6, 3'd0, 0, 32'hCAFEBABE, 1);
        do_req(1, 0, 32'h40, 3'd0, 0, 32'h11111111, 99);
        do_req(0, 1, 32'h41, 3'd3, 32'h55, 0, 1);
        do_req(1, 1, 32'h40, 3'd0, 0, 0, 1);
        do_req(1, 0, 32'h40, 3'd5, 0, 0, 1);
        do_req(0, 0, 32'h40, 3'd0, 0, 0, 1);
        do_req(1, 0, 32'h44, 3'd0, 0, 32'h89ABCDEF, TO);

        // Reset while the memory access is outstanding.
        @(negedge clk);
        req_valid = 1; req_load = 1; req_addr = 32'h80; req_width = 3'd0;
        @(negedge clk);
        req_valid = 0; req_load = 0;
        check("abort_mem_req", mem_req, 1);
        @(negedge clk);
        #2 rst = 1;
        #1;
        check("abort_mem_req_drop", mem_req, 0);
        check("abort_busy_drop", busy, 0);
        @(negedge clk); rst = 0;
        repeat (3) begin
            @(negedge clk);
            check("abort_no_resp", resp_valid, 0);
        end
        do_req(1, 0, 32'h81, 3'd3, 0, 32'h0000F700, 2);

        for (int i = 0; i < 40; i++) begin
            int unsigned op;
            logic [2:0] w;
            op = $urandom_range(0, 9);
            w  = ($urandom_range(0, 3) != 0) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(0, 7));
            do_req(op == 1 || (op >= 2 && op < 6), op == 1 || op >= 6, $urandom, w, $urandom,
                   $urandom, $urandom_range(1, TO + 2));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
